// File: rtl/spi_target_if.sv
// Bus bundle for spi_target: the SPI pins plus the byte-stream side toward the core.
interface spi_target_if;
    logic       spi_sck;
    logic       spi_ss;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       frame_start;
    logic       frame_end;

    // tx: a byte moves on a clk edge where tx_valid and tx_ready are both high; tx_valid
    // and tx_data hold until then. rx_valid is a one-clk strobe and is never back-pressured.
    modport slave (
        input  spi_sck, spi_ss, spi_mosi, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, frame_start, frame_end
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, frame_start, frame_end
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 responder, MSB first. Pins are oversampled in the clk domain; received
// bytes come out as strobes, transmit bytes go through a 1-deep holding register.
module spi_target #(
    parameter logic [7:0] FILL     = 8'hFF,
    parameter int         SYNC_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    spi_target_if.slave bus,
    output logic        dbg_active
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state;
    logic [SYNC_LEN-1:0] sck_sync, ss_sync, mosi_sync, ok_sync;
    logic                sck_prev, ss_prev, armed;
    logic [2:0]          bit_cnt;
    logic [6:0]          rx_shift, tx_shift;
    logic [7:0]          hold_data, rx_data_q;
    logic                hold_full;
    logic                miso_q, oe_q, rx_valid_q, fs_q, fe_q;

    logic       sck_s, ss_s, mosi_s;
    logic       sck_rise, sck_fall, ss_rise, ss_fall;
    logic       capture, load;
    logic [7:0] next_byte;

    assign sck_s  = sck_sync[SYNC_LEN-1];
    assign ss_s   = ss_sync[SYNC_LEN-1];
    assign mosi_s = mosi_sync[SYNC_LEN-1];

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    // ss edges count only once a genuine high ss has been seen since reset, so the
    // preset synchronizer value cannot fake a frame while the pin is still low.
    assign ss_fall  = armed & ss_prev & ~ss_s;
    assign ss_rise  = armed & ~ss_prev & ss_s;

    assign capture   = bus.tx_valid & ~hold_full;
    assign load      = ss_fall | ((state == ACTIVE) & ~ss_rise & sck_fall & (bit_cnt == 3'd0));
    assign next_byte = hold_full ? hold_data : FILL;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sck_sync   <= '0;
            ss_sync    <= '1;
            mosi_sync  <= '0;
            ok_sync    <= '0;
            sck_prev   <= 1'b0;
            ss_prev    <= 1'b1;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            rx_data_q  <= '0;
            miso_q     <= 1'b1;
            oe_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_LEN-2:0], bus.spi_sck};
            ss_sync   <= {ss_sync[SYNC_LEN-2:0], bus.spi_ss};
            mosi_sync <= {mosi_sync[SYNC_LEN-2:0], bus.spi_mosi};
            ok_sync   <= {ok_sync[SYNC_LEN-2:0], 1'b1};
            sck_prev  <= sck_s;
            ss_prev   <= ss_s;
            armed     <= armed | (ok_sync[SYNC_LEN-1] & ss_s);

            rx_valid_q <= 1'b0;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;

            // A capture can only happen while empty, so a same-cycle load takes FILL.
            if (capture) begin
                hold_data <= bus.tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (ss_rise) begin
                state   <= IDLE;
                fe_q    <= 1'b1;
                bit_cnt <= '0;
                miso_q  <= 1'b1;
                oe_q    <= 1'b0;
            end else if (ss_fall) begin
                state    <= ACTIVE;
                fs_q     <= 1'b1;
                oe_q     <= 1'b1;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= next_byte[6:0];
                miso_q   <= next_byte[7];
            end else if (state == ACTIVE) begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[5:0], mosi_s};
                    if (bit_cnt == 3'd7) begin
                        rx_data_q  <= {rx_shift, mosi_s};
                        rx_valid_q <= 1'b1;
                    end
                    bit_cnt <= bit_cnt + 3'd1;
                end else if (sck_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_shift <= next_byte[6:0];
                        miso_q   <= next_byte[7];
                    end else begin
                        miso_q   <= tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ready    = ~hold_full;
    assign bus.frame_start = fs_q;
    assign bus.frame_end   = fe_q;
    assign dbg_active      = (state == ACTIVE);
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a table of single-byte frames plus hand-written
// sequences for duplex, abort, no-tx, full-holding and mid-frame reset.
module tb_spi_target;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_active;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_target_if bus();

    spi_target #(.FILL(8'hFF), .SYNC_LEN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_active (dbg_active)
    );

    typedef struct {
        logic [7:0] mosi;
        logic       pre;
        logic [7:0] tx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp_q [$];
    int         n_cmp = 0, n_err = 0;
    int         rx_cnt = 0, fs_cnt = 0, fe_cnt = 0;
    int         exp_fs = 0, exp_fe = 0;
    int         last_rise = 0;
    logic       prev_rxv = 1'b0, prev_fs = 1'b0, prev_fe = 1'b0;
    logic [7:0] got, got2, got3;
    int         rx_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard for strobes, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                rx_cnt++;
                check("rx_strobe_width", 32'(prev_rxv), 32'd0);
                check("rx_latency", 32'(cyc - last_rise), 32'd3);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got byte 0x%0h, want no strobe", bus.rx_data);
                end else begin
                    check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.frame_start) begin
                fs_cnt++;
                check("frame_start_width", 32'(prev_fs), 32'd0);
            end
            if (bus.frame_end) begin
                fe_cnt++;
                check("frame_end_width", 32'(prev_fe), 32'd0);
            end
        end
        prev_rxv = bus.rx_valid;
        prev_fs  = bus.frame_start;
        prev_fe  = bus.frame_end;
    end

    // Initiator driver: mosi changes with the falling edge, miso is sampled at the rise.
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] miso_b);
        miso_b = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = b[i];
            tick(4);
            miso_b[i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            last_rise = cyc;
            tick(4);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic ss_low();
        bus.spi_ss = 1'b0;
        exp_fs++;
        tick(5);
        check("oe_in_frame", 32'(bus.spi_miso_oe), 32'd1);
        check("dbg_active", 32'(dbg_active), 32'd1);
    endtask

    task automatic ss_high();
        tick(4);
        bus.spi_ss = 1'b1;
        exp_fe++;
        tick(6);
        check("oe_after_frame", 32'(bus.spi_miso_oe), 32'd0);
        check("miso_idle", 32'(bus.spi_miso), 32'd1);
        check("frame_start_count", 32'(fs_cnt), 32'(exp_fs));
        check("frame_end_count", 32'(fe_cnt), 32'(exp_fe));
    endtask

    task automatic push_tx(input logic [7:0] b);
        logic hs;
        hs = 1'b0;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        for (int k = 0; k < 50 && !hs; k++) begin
            hs = bus.tx_ready;
            tick(1);
        end
        bus.tx_valid = 1'b0;
        check("tx_accept", 32'(hs), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{mosi: 8'hA5, pre: 1'b0, tx: 8'h00, exp_miso: 8'hFF};
        vecs[1] = '{mosi: 8'h3C, pre: 1'b1, tx: 8'h96, exp_miso: 8'h96};
        vecs[2] = '{mosi: 8'h00, pre: 1'b1, tx: 8'h01, exp_miso: 8'h01};
        vecs[3] = '{mosi: 8'hFF, pre: 1'b0, tx: 8'h00, exp_miso: 8'hFF};

        bus.spi_sck  = 1'b0;
        bus.spi_ss   = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset, then a quiet idle period.
        rst = 1'b1;
        tick(3);
        check("rst_miso", 32'(bus.spi_miso), 32'd1);
        check("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        rst = 1'b0;
        tick(100);
        check("idle_rx_count", 32'(rx_cnt), 32'd0);
        check("idle_fs_count", 32'(fs_cnt), 32'd0);
        check("idle_fe_count", 32'(fe_cnt), 32'd0);
        check("idle_miso", 32'(bus.spi_miso), 32'd1);
        check("idle_oe", 32'(bus.spi_miso_oe), 32'd0);

        // Single-byte frames from the table.
        foreach (vecs[v]) begin
            if (vecs[v].pre) begin
                push_tx(vecs[v].tx);
                check("vec_ready_full", 32'(bus.tx_ready), 32'd0);
            end
            ss_low();
            exp_q.push_back(vecs[v].mosi);
            send_bits(vecs[v].mosi, 8, got);
            ss_high();
            check("vec_miso", 32'(got), 32'(vecs[v].exp_miso));
            check("vec_ready_after", 32'(bus.tx_ready), 32'd1);
        end

        // Full duplex: 0x3C preloaded, 0xC3 offered during byte 1.
        push_tx(8'h3C);
        check("dup_ready_full", 32'(bus.tx_ready), 32'd0);
        ss_low();
        check("dup_ready_after_load", 32'(bus.tx_ready), 32'd1);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        fork
            send_bits(8'h12, 8, got);
            begin
                tick(10);
                push_tx(8'hC3);
                check("dup_ready_held", 32'(bus.tx_ready), 32'd0);
            end
        join
        check("dup_ready_at_fall", 32'(bus.tx_ready), 32'd0);
        tick(2);
        check("dup_ready_fall_p2", 32'(bus.tx_ready), 32'd0);
        tick(1);
        check("dup_ready_fall_p3", 32'(bus.tx_ready), 32'd1);
        send_bits(8'h34, 8, got2);
        ss_high();
        check("dup_miso0", 32'(got), 32'h3C);
        check("dup_miso1", 32'(got2), 32'hC3);

        // Abort after 5 bits, then a clean frame.
        rx_base = rx_cnt;
        ss_low();
        send_bits(8'hFF, 5, got);
        ss_high();
        check("abort_no_rx", 32'(rx_cnt), 32'(rx_base));
        ss_low();
        exp_q.push_back(8'h81);
        send_bits(8'h81, 8, got);
        ss_high();
        check("after_abort_miso", 32'(got), 32'hFF);
        check("after_abort_rx", 32'(rx_cnt), 32'(rx_base + 1));

        // Three bytes with nothing to transmit.
        ss_low();
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'h7E);
        send_bits(8'hDE, 8, got);
        send_bits(8'hAD, 8, got2);
        send_bits(8'h7E, 8, got3);
        ss_high();
        check("notx_miso0", 32'(got), 32'hFF);
        check("notx_miso1", 32'(got2), 32'hFF);
        check("notx_miso2", 32'(got3), 32'hFF);

        // Offer while full: the held byte must survive.
        push_tx(8'h77);
        bus.tx_data  = 8'h99;
        bus.tx_valid = 1'b1;
        tick(5);
        check("full_ready_low", 32'(bus.tx_ready), 32'd0);
        bus.tx_valid = 1'b0;
        ss_low();
        exp_q.push_back(8'h55);
        send_bits(8'h55, 8, got);
        ss_high();
        check("full_held_miso", 32'(got), 32'h77);
        check("full_ready_after", 32'(bus.tx_ready), 32'd1);

        // Reset after 4 bits with a held byte; later edges with ss still low are ignored.
        push_tx(8'h66);
        ss_low();
        send_bits(8'hF0, 4, got);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_miso", 32'(bus.spi_miso), 32'd1);
        check("mid_rst_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("mid_rst_fs", 32'(bus.frame_start), 32'd0);
        check("mid_rst_fe", 32'(bus.frame_end), 32'd0);
        check("mid_rst_active", 32'(dbg_active), 32'd0);
        rst = 1'b0;
        send_bits(8'hAA, 8, got);
        check("post_rst_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("post_rst_active", 32'(dbg_active), 32'd0);
        check("post_rst_no_frame", 32'(fs_cnt), 32'(exp_fs));
        tick(4);
        bus.spi_ss = 1'b1;
        tick(10);
        fs_cnt = 0;
        fe_cnt = 0;
        exp_fs = 0;
        exp_fe = 0;
        ss_low();
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 8, got);
        ss_high();
        check("post_rst_miso", 32'(got), 32'hFF);

        tick(10);
        check("rx_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
